surfctl_eye_scan: RTL and testbench

- Autonomous IDELAY eye-scan sequencer for one SURF input path (COUT or DOUT) on the TURFIO.
- Steps the IDELAY through every tap and runs a timed bit-error count at each one.
- Finds the longest contiguous run of good taps, then loads its centre tap.
- Sits in the wishbone clock domain. Drives the same load/count request points the control register core exposes, so software issues one start instead of NTAPS register sequences.

---
 rtl/surfctl_eye_scan.sv | 226 ++++++++++++++++++++++
 tb/tb_surfctl_eye_scan.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/surfctl_eye_scan.sv
// Autonomous IDELAY eye-scan sequencer for one SURF input path.
// Steps every tap, runs a timed bit-error count at each one, tracks the
// longest contiguous run of good taps and finally loads its centre tap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start_i; eye results hold
// S_LOAD   | idelay_load_o high with idelay_value_o, waiting for ack
// S_COUNT  | biterr_req_o high, waiting for biterr_valid_i
// S_EVAL   | judge the tap, update run/best trackers, advance the tap
// S_CENTER | decide pass/fail, pick the centre tap for the final load
// S_FINISH | one cycle: done_o pulse, eye outputs valid
module surfctl_eye_scan #(
  parameter int TAP_BITS      = 5,
  parameter int COUNT_BITS    = 25,
  parameter int INTERVAL_BITS = 24,
  parameter int MIN_EYE       = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [INTERVAL_BITS-1:0] interval_i,
  input  logic [COUNT_BITS-1:0]    threshold_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     fail_o,
  output logic [TAP_BITS-1:0]      idelay_value_o,
  output logic                     idelay_load_o,
  input  logic                     idelay_ack_i,
  output logic                     biterr_req_o,
  output logic [INTERVAL_BITS-1:0] biterr_interval_o,
  input  logic [COUNT_BITS-1:0]    biterr_count_i,
  input  logic                     biterr_valid_i,
  output logic [TAP_BITS-1:0]      eye_start_o,
  output logic [TAP_BITS:0]        eye_width_o,
  output logic [TAP_BITS-1:0]      eye_center_o
);

  localparam logic [TAP_BITS-1:0] TAP_MAX = '1;
  localparam logic [TAP_BITS-1:0] TAP_ONE = TAP_BITS'(1);
  localparam logic [TAP_BITS:0]   LEN_ONE = (TAP_BITS + 1)'(1);
  localparam logic [TAP_BITS:0]   MIN_LEN = (TAP_BITS + 1)'(MIN_EYE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_EVAL,
    S_CENTER,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [TAP_BITS-1:0]      tap_q;
  logic [TAP_BITS-1:0]      value_q;
  logic [INTERVAL_BITS-1:0] interval_q;
  logic [COUNT_BITS-1:0]    thr_q;
  logic [COUNT_BITS-1:0]    count_q;
  logic [TAP_BITS-1:0]      run_start_q;
  logic [TAP_BITS:0]        run_len_q;
  logic [TAP_BITS-1:0]      best_start_q;
  logic [TAP_BITS:0]        best_len_q;
  logic                     fail_q;
  logic                     final_q;
  logic [TAP_BITS-1:0]      eye_start_q;
  logic [TAP_BITS:0]        eye_width_q;
  logic [TAP_BITS-1:0]      eye_center_q;

  logic                     tap_good;
  logic [TAP_BITS:0]        run_len_inc;
  logic [TAP_BITS-1:0]      run_start_new;
  logic [TAP_BITS-1:0]      centre;
  logic                     eye_ok;
  logic                     abort_hit;

  // Tap judgement, run bookkeeping and centre arithmetic.
  // The centre sum is formed one bit wider and floored; it never exceeds TAP_MAX
  // because best_start + best_len - 1 is itself a valid tap.
  always_comb begin
    tap_good      = (count_q <= thr_q);
    run_len_inc   = run_len_q + LEN_ONE;
    run_start_new = (run_len_q == '0) ? tap_q : run_start_q;
    centre        = TAP_BITS'({1'b0, best_start_q} + ((best_len_q - LEN_ONE) >> 1));
    eye_ok        = (best_len_q >= MIN_LEN);
    abort_hit     = abort_i && (state_q != S_IDLE) && (state_q != S_FINISH);
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next state and handshake outputs; abort overrides any pending ack/valid.
  always_comb begin
    state_d       = state_q;
    idelay_load_o = 1'b0;
    biterr_req_o  = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy_o        = 1'b1;
        idelay_load_o = 1'b1;
        if (idelay_ack_i) state_d = final_q ? S_FINISH : S_COUNT;
      end
      S_COUNT: begin
        busy_o       = 1'b1;
        biterr_req_o = 1'b1;
        if (biterr_valid_i) state_d = S_EVAL;
      end
      S_EVAL: begin
        busy_o  = 1'b1;
        state_d = (tap_q == TAP_MAX) ? S_CENTER : S_LOAD;
      end
      S_CENTER: begin
        busy_o  = 1'b1;
        state_d = eye_ok ? S_LOAD : S_FINISH;
      end
      S_FINISH: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_FINISH;
  end

  // Scan datapath: latched settings, tap counter, run/best trackers, results.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tap_q        <= '0;
      value_q      <= '0;
      interval_q   <= '0;
      thr_q        <= '0;
      count_q      <= '0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      fail_q       <= 1'b0;
      final_q      <= 1'b0;
      eye_start_q  <= '0;
      eye_width_q  <= '0;
      eye_center_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start_i) begin
        interval_q   <= interval_i;
        thr_q        <= threshold_i;
        tap_q        <= '0;
        value_q      <= '0;
        run_start_q  <= '0;
        run_len_q    <= '0;
        best_start_q <= '0;
        best_len_q   <= '0;
        fail_q       <= 1'b0;
        final_q      <= 1'b0;
        eye_start_q  <= '0;
        eye_width_q  <= '0;
        eye_center_q <= '0;
      end
    end else if (abort_hit) begin
      fail_q       <= 1'b1;
      final_q      <= 1'b0;
      eye_start_q  <= best_start_q;
      eye_width_q  <= best_len_q;
      eye_center_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (idelay_ack_i && final_q) begin
            final_q      <= 1'b0;
            eye_start_q  <= best_start_q;
            eye_width_q  <= best_len_q;
            eye_center_q <= value_q;
          end
        end
        S_COUNT: begin
          if (biterr_valid_i) count_q <= biterr_count_i;
        end
        S_EVAL: begin
          if (tap_good) begin
            run_start_q <= run_start_new;
            run_len_q   <= run_len_inc;
            if (run_len_inc > best_len_q) begin
              best_start_q <= run_start_new;
              best_len_q   <= run_len_inc;
            end
          end else begin
            run_len_q <= '0;
          end
          if (tap_q != TAP_MAX) begin
            tap_q   <= tap_q + TAP_ONE;
            value_q <= tap_q + TAP_ONE;
          end
        end
        S_CENTER: begin
          if (eye_ok) begin
            value_q <= centre;
            final_q <= 1'b1;
          end else begin
            // IDELAY stays at the last scanned tap; no final load.
            fail_q       <= 1'b1;
            eye_start_q  <= best_start_q;
            eye_width_q  <= best_len_q;
            eye_center_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign fail_o            = fail_q;
  assign idelay_value_o    = value_q;
  assign biterr_interval_o = interval_q;
  assign eye_start_o       = eye_start_q;
  assign eye_width_o       = eye_width_q;
  assign eye_center_o      = eye_center_q;

endmodule

// File: tb/tb_surfctl_eye_scan.sv
// Bench for surfctl_eye_scan: acts as the IDELAY/bit-error far side with
// random response latencies; expected tap loads are queued per scenario
// and popped as each load is acknowledged.
module tb_surfctl_eye_scan;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        start_i, abort_i;
  logic [23:0] interval_i;
  logic [24:0] threshold_i;
  logic        busy_o, done_o, fail_o;
  logic [4:0]  idelay_value_o;
  logic        idelay_load_o, idelay_ack_i;
  logic        biterr_req_o;
  logic [23:0] biterr_interval_o;
  logic [24:0] biterr_count_i;
  logic        biterr_valid_i;
  logic [4:0]  eye_start_o;
  logic [5:0]  eye_width_o;
  logic [4:0]  eye_center_o;

  surfctl_eye_scan dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .start_i(start_i), .abort_i(abort_i),
    .interval_i(interval_i), .threshold_i(threshold_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .idelay_value_o(idelay_value_o), .idelay_load_o(idelay_load_o),
    .idelay_ack_i(idelay_ack_i),
    .biterr_req_o(biterr_req_o), .biterr_interval_o(biterr_interval_o),
    .biterr_count_i(biterr_count_i), .biterr_valid_i(biterr_valid_i),
    .eye_start_o(eye_start_o), .eye_width_o(eye_width_o),
    .eye_center_o(eye_center_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          viol;
  int          cnt_tab[32];
  int          exp_taps[$];
  logic [23:0] ival;
  logic [24:0] thr;
  bit          got_done;
  logic [16:0] d_eye;
  logic [4:0]  d_value;
  logic        d_load, d_req;

  task automatic set_range(input int lo, input int hi, input int val);
    for (int i = lo; i <= hi; i++) cnt_tab[i] = val;
  endtask

  task automatic push_taps(input int last, input int centre);
    for (int i = 0; i <= last; i++) exp_taps.push_back(i);
    if (centre >= 0) exp_taps.push_back(centre);
  endtask

  task automatic do_start();
    ival = 24'($urandom_range(1, 24'hFFFFFF));
    @(negedge wb_clk_i);
    start_i = 1'b1; interval_i = ival; threshold_i = thr;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    interval_i = ~ival;
    threshold_i = '0;
  endtask

  // Far-side responder; runs until done_o, the reset tap, or the budget expires.
  task automatic drive_scan(input int abort_tap, input int rst_tap,
                            input bit poke_start, input int budget);
    int ld_wait, ct_wait, last, exp_v;
    bit stop, poke, prev_load;
    logic [4:0] prev_value;
    got_done = 0; stop = 0; last = -1; viol = 0; poke = poke_start;
    prev_load = 0; prev_value = '0;
    ld_wait = $urandom_range(0, 2); ct_wait = $urandom_range(0, 2);
    for (int cyc = 0; cyc < budget && !stop; cyc++) begin
      @(negedge wb_clk_i);
      idelay_ack_i = 1'b0; biterr_valid_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
      if (done_o) begin
        got_done = 1; stop = 1;
        d_eye = {eye_start_o, eye_width_o, eye_center_o, fail_o};
        d_value = idelay_value_o; d_load = idelay_load_o; d_req = biterr_req_o;
      end else begin
        if (idelay_load_o && biterr_req_o) viol++;
        if (busy_o && biterr_interval_o !== ival) viol++;
        if (idelay_load_o && prev_load && idelay_value_o !== prev_value) viol++;
        prev_load = idelay_load_o; prev_value = idelay_value_o;
        if (idelay_load_o) begin
          if (rst_tap >= 0 && int'(idelay_value_o) == rst_tap) begin
            #2 wb_rst_n_i = 1'b0;
            stop = 1;
          end else if (ld_wait == 0) begin
            idelay_ack_i = 1'b1;
            last = int'(idelay_value_o);
            n_checks++;
            if (exp_taps.size() == 0) begin
              $display("FAIL load_seq: unexpected load of tap %0d", idelay_value_o);
            end else begin
              exp_v = exp_taps.pop_front();
              if (int'(idelay_value_o) !== exp_v)
                $display("FAIL load_seq: got tap %0d, want %0d", idelay_value_o, exp_v);
              else n_pass++;
            end
            ld_wait = $urandom_range(0, 2);
          end else ld_wait--;
        end
        if (biterr_req_o && last >= 0) begin
          if (poke && last == 2) begin start_i = 1'b1; poke = 0; end
          if (abort_tap >= 0 && last == abort_tap) begin
            abort_i = 1'b1; biterr_valid_i = 1'b1; biterr_count_i = '0;
          end else if (ct_wait == 0) begin
            biterr_valid_i = 1'b1;
            biterr_count_i = 25'(cnt_tab[last]);
            ct_wait = $urandom_range(0, 2);
          end else ct_wait--;
        end
      end
    end
    if (!stop) begin
      n_checks++;
      $display("FAIL scan_timeout: no done_o within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    logic [49:0] outs;
    wb_rst_n_i = 1'b0; start_i = 0; abort_i = 0; interval_i = '0; threshold_i = '0;
    idelay_ack_i = 0; biterr_valid_i = 0; biterr_count_i = '0;
    #1;
    outs = {busy_o, done_o, fail_o, idelay_value_o, idelay_load_o, biterr_req_o,
            biterr_interval_o, eye_start_o, eye_width_o, eye_center_o};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h, want 0", outs);
    else n_pass++;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
  endtask

  task automatic test_all_good();
    set_range(0, 31, 0); thr = 0;
    push_taps(31, 15);
    do_start();
    n_checks++;
    if ({idelay_load_o, idelay_value_o, busy_o, fail_o} !== {1'b1, 5'd0, 1'b1, 1'b0})
      $display("FAIL first_load: load=%b val=%0d busy=%b fail=%b, want 1 0 1 0",
               idelay_load_o, idelay_value_o, busy_o, fail_o);
    else n_pass++;
    drive_scan(-1, -1, 0, 2000);
    n_checks++;
    if ({got_done, d_eye, d_value} !== {1'b1, 5'd0, 6'd32, 5'd15, 1'b0, 5'd15})
      $display("FAIL all_good_eye: done=%b eye=%h val=%0d, want 1 %h 15",
               got_done, d_eye, d_value, {5'd0, 6'd32, 5'd15, 1'b0});
    else n_pass++;
    n_checks++;
    if (exp_taps.size() + viol != 0)
      $display("FAIL all_good_hs: pending=%0d viol=%0d, want 0 0", exp_taps.size(), viol);
    else n_pass++;
    exp_taps.delete();
    @(negedge wb_clk_i);
    n_checks++;
    if ({done_o, busy_o} !== 2'b00)
      $display("FAIL done_single: done=%b busy=%b, want 0 0", done_o, busy_o);
    else n_pass++;
  endtask

  task automatic test_center_window();
    set_range(0, 31, 1000); set_range(8, 19, 0); thr = 10;
    push_taps(31, 13);
    do_start();
    drive_scan(-1, -1, 0, 2000);
    n_checks++;
    if ({got_done, d_eye, d_value} !== {1'b1, 5'd8, 6'd12, 5'd13, 1'b0, 5'd13})
      $display("FAIL window_eye: eye=%h val=%0d, want %h 13", d_eye, d_value,
               {5'd8, 6'd12, 5'd13, 1'b0});
    else n_pass++;
    n_checks++;
    if (exp_taps.size() + viol != 0)
      $display("FAIL window_hs: pending=%0d viol=%0d, want 0 0", exp_taps.size(), viol);
    else n_pass++;
    exp_taps.delete();
  endtask

  task automatic test_two_windows();
    set_range(0, 31, 500); set_range(2, 5, 0); set_range(20, 27, 0); thr = 0;
    push_taps(31, 23);
    do_start();
    drive_scan(-1, -1, 0, 2000);
    n_checks++;
    if ({got_done, d_eye} !== {1'b1, 5'd20, 6'd8, 5'd23, 1'b0})
      $display("FAIL two_windows_eye: eye=%h, want %h", d_eye, {5'd20, 6'd8, 5'd23, 1'b0});
    else n_pass++;
    exp_taps.delete();
  endtask

  task automatic test_tie();
    set_range(0, 31, 500); set_range(0, 3, 0); set_range(10, 13, 0); thr = 0;
    push_taps(31, 1);
    do_start();
    drive_scan(-1, -1, 0, 2000);
    n_checks++;
    if ({got_done, d_eye} !== {1'b1, 5'd0, 6'd4, 5'd1, 1'b0})
      $display("FAIL tie_eye: eye=%h, want %h", d_eye, {5'd0, 6'd4, 5'd1, 1'b0});
    else n_pass++;
    n_checks++;
    if (exp_taps.size() != 0) $display("FAIL tie_loads: pending=%0d, want 0", exp_taps.size());
    else n_pass++;
    exp_taps.delete();
  endtask

  task automatic test_threshold_edge();
    set_range(0, 31, 51); set_range(4, 9, 50); thr = 50;
    push_taps(31, 6);
    do_start();
    drive_scan(-1, -1, 0, 2000);
    n_checks++;
    if ({got_done, d_eye} !== {1'b1, 5'd4, 6'd6, 5'd6, 1'b0})
      $display("FAIL thr_edge_eye: eye=%h, want %h", d_eye, {5'd4, 6'd6, 5'd6, 1'b0});
    else n_pass++;
    exp_taps.delete();
  endtask

  task automatic test_all_bad();
    set_range(0, 31, 51); thr = 50;
    push_taps(31, -1);
    do_start();
    drive_scan(-1, -1, 0, 2000);
    n_checks++;
    if ({got_done, d_eye, d_value, d_load} !== {1'b1, 5'd0, 6'd0, 5'd0, 1'b1, 5'd31, 1'b0})
      $display("FAIL all_bad: done=%b eye=%h val=%0d load=%b, want 1 %h 31 0",
               got_done, d_eye, d_value, d_load, {5'd0, 6'd0, 5'd0, 1'b1});
    else n_pass++;
    n_checks++;
    if (exp_taps.size() != 0) $display("FAIL all_bad_loads: pending=%0d, want 0", exp_taps.size());
    else n_pass++;
    exp_taps.delete();
  endtask

  task automatic test_abort();
    set_range(0, 31, 0); thr = 0;
    push_taps(6, -1);
    do_start();
    drive_scan(6, -1, 1, 2000);
    n_checks++;
    if ({got_done, d_req, d_load, d_eye} !== {1'b1, 1'b0, 1'b0, 5'd0, 6'd6, 5'd0, 1'b1})
      $display("FAIL abort: done=%b req=%b load=%b eye=%h, want 1 0 0 %h",
               got_done, d_req, d_load, d_eye, {5'd0, 6'd6, 5'd0, 1'b1});
    else n_pass++;
    n_checks++;
    if (exp_taps.size() + viol != 0)
      $display("FAIL abort_loads: pending=%0d viol=%0d, want 0 0", exp_taps.size(), viol);
    else n_pass++;
    exp_taps.delete();
    @(negedge wb_clk_i);
    n_checks++;
    if ({done_o, busy_o, fail_o} !== 3'b001)
      $display("FAIL abort_after: done=%b busy=%b fail=%b, want 0 0 1", done_o, busy_o, fail_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_range(0, 31, 1000); set_range(8, 19, 0); thr = 10;
    push_taps(31, 13);
    do_start();
    n_checks++;
    if ({fail_o, busy_o} !== 2'b01)
      $display("FAIL restart_clears_fail: fail=%b busy=%b, want 0 1", fail_o, busy_o);
    else n_pass++;
    drive_scan(-1, -1, 0, 2000);
    n_checks++;
    if ({got_done, d_eye} !== {1'b1, 5'd8, 6'd12, 5'd13, 1'b0})
      $display("FAIL back_to_back_eye: eye=%h, want %h", d_eye, {5'd8, 6'd12, 5'd13, 1'b0});
    else n_pass++;
    exp_taps.delete();
  endtask

  task automatic test_async_reset();
    logic [49:0] outs;
    bit saw;
    set_range(0, 31, 0); thr = 0;
    push_taps(3, -1);
    do_start();
    drive_scan(-1, 3, 0, 2000);
    #1;
    outs = {busy_o, done_o, fail_o, idelay_value_o, idelay_load_o, biterr_req_o,
            biterr_interval_o, eye_start_o, eye_width_o, eye_center_o};
    n_checks++;
    if ({wb_rst_n_i, outs} !== 51'd0)
      $display("FAIL async_reset: rst=%b outs=%h, want 0 0", wb_rst_n_i, outs);
    else n_pass++;
    n_checks++;
    if (exp_taps.size() != 1)
      $display("FAIL async_reset_loads: pending=%0d, want 1", exp_taps.size());
    else n_pass++;
    exp_taps.delete();
    saw = 0;
    repeat (2) begin @(negedge wb_clk_i); saw |= done_o; end
    wb_rst_n_i = 1'b1;
    repeat (5) begin @(negedge wb_clk_i); saw |= done_o | busy_o; end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL async_reset_quiet: done/busy seen=%b, want 0", saw);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_all_good();
    test_center_window();
    test_two_windows();
    test_tie();
    test_threshold_edge();
    test_all_bad();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_all_good();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
